// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency loads and stores on a shared bidirectional bus, plus a valid/ready memory dump after halt.
// Optional macro DMEM_ERR_EN adds a sticky err output for out-of-range or misaligned stores.
`default_nettype none

module dmem_responder #(
  parameter int DEPTH      = 1152,
  parameter int AW         = $clog2(DEPTH),
  parameter int DUMP_WORDS = DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [63:0] mem_data,
  input  logic        mem_rw,
  input  logic [63:0] addr,
  input  logic        halt,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [63:0] dump_addr,
  output logic [63:0] dump_data,
`ifdef DMEM_ERR_EN
  output logic        dump_done,
  output logic        err
`else
  output logic        dump_done
`endif
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DUMP_WORDS - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic          in_range;
  logic          wr_en;

  assign idx      = addr[AW+2:3];
  assign in_range = addr < (64'(DEPTH) * 64'd8);
  assign wr_en    = (state == RUN) && mem_rw && in_range;
  assign ptr_nxt  = ptr + AW'(1);

  // The bus is released whenever the core drives a store.
  assign mem_data = mem_rw ? 64'bz : (in_range ? mem[idx] : 64'h0);

  // Storage is not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= mem_data;
    end
  end

  // Writes are blocked outside RUN, so mem[ptr] is a frozen image during the dump.
  assign dump_data = dump_valid ? mem[ptr] : 64'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ptr        <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= 64'h0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state      <= DUMP;
            ptr        <= '0;
            dump_valid <= 1'b1;
            dump_addr  <= 64'h0;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (ptr == LAST_PTR) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              ptr       <= ptr_nxt;
              dump_addr <= {{(61-AW){1'b0}}, ptr_nxt, 3'b000};
            end
          end
        end
        DONE: begin
          dump_valid <= 1'b0;
          dump_done  <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef DMEM_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == RUN) && mem_rw && (!in_range || (addr[2:0] != 3'b000))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder with a word-array reference model.
`default_nettype none

module tb_dmem_responder;

  localparam int          DEPTH = 1152;
  localparam int          AW    = 11;
  localparam int          DW    = 4;
  localparam logic [63:0] LIM   = 64'd9216;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rw = 1'b0;
  logic [63:0] addr = 64'h0;
  logic        halt = 1'b0;
  logic        dump_ready = 1'b0;
  logic        dump_valid;
  logic [63:0] dump_addr;
  logic [63:0] dump_data;
  logic        dump_done;
  logic        bus_en = 1'b0;
  logic [63:0] bus_drv = 64'h0;
  logic        chk_load = 1'b0;
  wire  [63:0] mem_data;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  assign mem_data = bus_en ? bus_drv : 64'bz;

  dmem_responder #(.DEPTH(DEPTH), .DUMP_WORDS(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_data   (mem_data),
    .mem_rw     (mem_rw),
    .addr       (addr),
    .halt       (halt),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
`ifdef DMEM_ERR_EN
    .dump_done  (dump_done),
    .err        (err)
`else
    .dump_done  (dump_done)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus dump/load expectation queues.
  logic [63:0] model [DEPTH];
  logic [63:0] load_q [$];
  logic [63:0] exp_addr_q [$];
  logic [63:0] exp_data_q [$];
  logic [63:0] written [$];
  bit          frozen = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a load result or a dump handshake.
  bit          held = 1'b0;
  logic [63:0] last_addr, last_data;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_en) check("store_bus", mem_data, bus_drv);
      if (chk_load) begin
        if (load_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL load_q: no expectation for load at %h", addr);
        end else begin
          check("load", mem_data, load_q.pop_front());
        end
      end
      if (dump_valid) begin
        if (held) begin
          check("hold_addr", dump_addr, last_addr);
          check("hold_data", dump_data, last_data);
        end
        if (dump_ready) begin
          held = 1'b0;
          if (exp_addr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL dump_extra: got addr %h expected none", dump_addr);
          end else begin
            check("dump_addr", dump_addr, exp_addr_q.pop_front());
            check("dump_data", dump_data, exp_data_q.pop_front());
          end
        end else begin
          held      = 1'b1;
          last_addr = dump_addr;
          last_data = dump_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // One bus cycle; inputs change 1 time unit after the rising edge.
  task automatic step(input bit rw, input logic [63:0] a, input logic [63:0] d, input bit h, input bit ld);
    mem_rw   = rw;
    bus_en   = rw;
    bus_drv  = d;
    addr     = a;
    halt     = h;
    chk_load = ld && !rw;
    if (ld && !rw) load_q.push_back((a < LIM) ? model[a[AW+2:3]] : 64'h0);
    if (rw && !frozen && (a < LIM)) model[a[AW+2:3]] = d;
    @(posedge clk);
    #1;
    if (h && !frozen) begin
      frozen = 1'b1;
      for (int i = 0; i < DW; i++) begin
        exp_addr_q.push_back(64'(i) * 64'd8);
        exp_data_q.push_back(model[i]);
      end
    end
    mem_rw = 1'b0; bus_en = 1'b0; halt = 1'b0; chk_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", {63'h0, dump_valid}, 64'h0);
    check("rst_done",  {63'h0, dump_done},  64'h0);
    exp_addr_q.delete();
    exp_data_q.delete();
    frozen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] a, d, w;
    int r;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {63'h0, dump_valid}, 64'h0);
    check("reset_done",  {63'h0, dump_done},  64'h0);
    check("reset_daddr", dump_addr, 64'h0);
    check("reset_ddata", dump_data, 64'h0);
`ifdef DMEM_ERR_EN
    check("reset_err", {63'h0, err}, 64'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, 64'(i) * 64'd8, d, 1'b0, 1'b0);
      written.push_back(64'(i) * 64'd8);
    end

    // Store then load, same address, next cycle
    step(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
    step(1'b0, 64'h40, 64'h0, 1'b0, 1'b1);

    // Out-of-range store is dropped; last in-range word works
    step(1'b1, LIM, 64'h1234, 1'b0, 1'b0);
`ifdef DMEM_ERR_EN
    check("err_oor", {63'h0, err}, 64'h1);
`endif
    step(1'b0, LIM, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    step(1'b1, LIM - 64'd8, 64'hA5A5_0000_FFFF_1111, 1'b0, 1'b0);
    step(1'b0, LIM - 64'd8, 64'h0, 1'b0, 1'b1);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 3);
      if (r < 2) begin
        w = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
        a = w + 64'($urandom_range(0, 7));
        step(1'b1, a, {$urandom, $urandom}, 1'b0, 1'b0);
        written.push_back(w);
      end else if (r == 2) begin
        w = written[$urandom_range(0, written.size() - 1)];
        step(1'b0, w + 64'($urandom_range(0, 7)), 64'h0, 1'b0, 1'b1);
      end else begin
        a = LIM + 64'($urandom_range(0, 100000));
        if ($urandom_range(0, 1) == 1) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        step(1'b0, a, 64'h0, 1'b0, 1'b1);
      end
    end

    // Dump A: halt with concurrent store, backpressure, frozen image
    step(1'b1, 64'h0, 64'h55, 1'b1, 1'b0);
    check("dumpA_first_valid", {63'h0, dump_valid}, 64'h1);
    dump_ready = 1'b1;
    step(1'b1, 64'h8, 64'h99, 1'b0, 1'b0);
    dump_ready = 1'b0;
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    dump_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    dump_ready = 1'b0;
    check("dumpA_done",   {63'h0, dump_done},  64'h1);
    check("dumpA_valid",  {63'h0, dump_valid}, 64'h0);
    check("dumpA_remain", 64'(exp_addr_q.size()), 64'h0);
    step(1'b0, 64'h8, 64'h0, 1'b0, 1'b1);

    // Dump B: reset after two accepted words
    do_reset();
    step(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    dump_ready = 1'b1;
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check("dumpB_taken", 64'(exp_addr_q.size()), 64'd2);
    do_reset();
    dump_ready = 1'b0;
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    // Dump C: ready held high, done four cycles after valid rises
    dump_ready = 1'b1;
    step(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check("dumpC_first_valid", {63'h0, dump_valid}, 64'h1);
    check("dumpC_first_addr",  dump_addr, 64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check("dumpC_not_done", {63'h0, dump_done}, 64'h0);
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check("dumpC_done", {63'h0, dump_done}, 64'h1);
    dump_ready = 1'b0;
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    check("load_q_empty", 64'(load_q.size()), 64'h0);
    check("dump_q_empty", 64'(exp_addr_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
